// File: rtl/fft_reorder_pkg.sv
// fft_reorder_pkg: shared lane constants and index helpers for the FFT output reorder stage
package fft_reorder_pkg;
  localparam int LANES = 4;
  localparam int LANE0_UP = 0;
  localparam int LANE0_DOWN = 1;
  localparam int LANE1_UP = 2;
  localparam int LANE1_DOWN = 3;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int logn);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) if (i < logn) r[logn-1-i] = idx[i];
    return r;
  endfunction
endpackage

// File: rtl/reorder_bank.sv
// reorder_bank: one ping-pong half, 4 scattered write ports and 4 read ports at one aligned beat
module reorder_bank import fft_reorder_pkg::*; #(
  parameter int W = 30,
  parameter int N = 128,
  parameter int AW = clog2(N)
) (
  input  logic clk,
  input  logic [LANES-1:0] we,
  input  logic [LANES-1:0][AW-1:0] wAddr,
  input  logic [LANES-1:0][W-1:0] wData,
  input  logic [AW-3:0] rBeat,
  output logic [LANES-1:0][W-1:0] rData
);
  logic [W-1:0] mem [N];
  always_ff @(posedge clk)
    for (int l = 0; l < LANES; l++) if (we[l]) mem[wAddr[l]] <= wData[l];
  always_comb
    for (int l = 0; l < LANES; l++) rData[l] = mem[{rBeat, 2'(l)}];
endmodule

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: converts the bit-reversed 4-lane FFT stream to natural bin order via ping-pong banks
module fft_out_reorder import fft_reorder_pkg::*; #(
  parameter int NBITS_out = 15,
  parameter int N = 128,
  parameter int LOGN = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_sof,
  input  logic [2*NBITS_out-1:0] fftIn0_up,
  input  logic [2*NBITS_out-1:0] fftIn0_down,
  input  logic [2*NBITS_out-1:0] fftIn1_up,
  input  logic [2*NBITS_out-1:0] fftIn1_down,
  output logic out_valid,
  output logic out_sof,
  output logic [2*NBITS_out-1:0] out_bin0,
  output logic [2*NBITS_out-1:0] out_bin1,
  output logic [2*NBITS_out-1:0] out_bin2,
  output logic [2*NBITS_out-1:0] out_bin3,
  output logic frame_err
);
  localparam int W = 2*NBITS_out;
  localparam int CW = LOGN-2;
  localparam logic [CW-1:0] LAST = CW'(N/4-1);
  logic [CW-1:0] wc, rc, cEff;
  logic wrBank, rdBank, accept, err, done;
  logic [1:0] full;
  logic [LANES-1:0][W-1:0] inLane, rSel;
  logic [LANES-1:0][LOGN-1:0] wAddr;
  logic [1:0][LANES-1:0][W-1:0] rData;
  always_comb begin
    inLane[LANE0_UP] = fftIn0_up;
    inLane[LANE0_DOWN] = fftIn0_down;
    inLane[LANE1_UP] = fftIn1_up;
    inLane[LANE1_DOWN] = fftIn1_down;
    accept = in_valid && (in_sof || wc != '0);
    err = in_valid && (in_sof == (wc != '0));
    cEff = in_sof ? '0 : wc;
    done = accept && cEff == LAST;
    for (int l = 0; l < LANES; l++) wAddr[l] = LOGN'(bitrev(32'({cEff, 2'(l)}), LOGN));
    rSel = rData[rdBank];
  end
  genvar b;
  generate
    for (b = 0; b < 2; b++) begin : bank
      reorder_bank #(.W(W), .N(N), .AW(LOGN)) u_bank (
        .clk(clk),
        .we({LANES{accept && wrBank == 1'(b)}}),
        .wAddr(wAddr),
        .wData(inLane),
        .rBeat(rc),
        .rData(rData[b])
      );
    end
  endgenerate
  // A bank stays full for its whole drain, so full[rdBank] alone gates readout
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wc <= '0;
      rc <= '0;
      wrBank <= 1'b0;
      rdBank <= 1'b0;
      full <= '0;
      out_valid <= 1'b0;
      out_sof <= 1'b0;
      out_bin0 <= '0;
      out_bin1 <= '0;
      out_bin2 <= '0;
      out_bin3 <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err;
      if (accept) wc <= done ? '0 : cEff + 1'b1;
      out_valid <= full[rdBank];
      out_sof <= full[rdBank] && rc == '0;
      out_bin0 <= full[rdBank] ? rSel[0] : '0;
      out_bin1 <= full[rdBank] ? rSel[1] : '0;
      out_bin2 <= full[rdBank] ? rSel[2] : '0;
      out_bin3 <= full[rdBank] ? rSel[3] : '0;
      if (full[rdBank]) begin
        rc <= rc + 1'b1;
        if (rc == LAST) begin
          full[rdBank] <= 1'b0;
          rdBank <= ~rdBank;
        end
      end
      if (done) begin
        full[wrBank] <= 1'b1;
        wrBank <= ~wrBank;
      end
    end
endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: directed checks of bit-reversed to natural-order reordering
module tb_fft_out_reorder;
  logic clk = 0, rst = 1, in_valid = 0, in_sof = 0;
  logic [29:0] fftIn0_up = '0, fftIn0_down = '0, fftIn1_up = '0, fftIn1_down = '0;
  logic out_valid, out_sof, frame_err;
  logic [29:0] out_bin0, out_bin1, out_bin2, out_bin3;
  logic [119:0] outBins;
  int total = 0, bad = 0;
  int vCnt = 0, sofCnt = 0, errCnt = 0, run = 0, maxRun = 0, kk = 0, mode = 0;
  fft_out_reorder #(.NBITS_out(15), .N(128), .LOGN(7)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
    .fftIn0_up(fftIn0_up), .fftIn0_down(fftIn0_down),
    .fftIn1_up(fftIn1_up), .fftIn1_down(fftIn1_down),
    .out_valid(out_valid), .out_sof(out_sof),
    .out_bin0(out_bin0), .out_bin1(out_bin1), .out_bin2(out_bin2), .out_bin3(out_bin3),
    .frame_err(frame_err)
  );
  assign outBins = {out_bin3, out_bin2, out_bin1, out_bin0};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int br(input int x);
    int r;
    r = 0;
    for (int i = 0; i < 7; i++) if (x[i]) r = r | (1 << (6 - i));
    return r;
  endfunction
  function automatic logic [29:0] word(input int bin);
    logic [14:0] r;
    r = 15'(bin);
    if (mode == 1 && bin % 2 == 0) return {15'h4000, 15'h3FFF};
    if (mode == 2) r = r ^ 15'h155;
    return {r, ~r};
  endfunction
  function automatic logic [119:0] expBeat(input int k);
    logic [119:0] e;
    for (int l = 0; l < 4; l++) e[30*l +: 30] = word(4*k + l);
    return e;
  endfunction
  always @(negedge clk)
    if (rst) begin
      kk = 0;
      run = 0;
    end else begin
      if (frame_err) errCnt++;
      if (out_valid) begin
        vCnt++;
        run++;
        if (run > maxRun) maxRun = run;
        if (out_sof) sofCnt++;
        chk("mon_sof", 128'(out_sof), 128'(kk == 0));
        chk("mon_bins", 128'(outBins), 128'(expBeat(kk)));
        kk = (kk + 1) % 32;
      end else begin
        run = 0;
        chk("mon_idle", 128'({out_sof, outBins}), 128'(0));
      end
    end
  task automatic beat(input int c, input bit sof);
    in_valid = 1;
    in_sof = sof;
    fftIn0_up = word(br(4*c));
    fftIn0_down = word(br(4*c + 1));
    fftIn1_up = word(br(4*c + 2));
    fftIn1_down = word(br(4*c + 3));
    @(posedge clk); #1;
    in_valid = 0;
    in_sof = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic frame(input int gap);
    for (int c = 0; c < 32; c++) begin
      beat(c, c == 0);
      if (gap > 0) idle(gap);
    end
  endtask
  task automatic latFrame(input string tag);
    frame(0);
    chk({tag, "_lat_pre"}, 128'(out_valid), 128'(0));
    @(posedge clk); #1;
    chk({tag, "_lat_sof"}, 128'({out_valid, out_sof}), 128'(3));
    chk({tag, "_lat_bins"}, 128'(outBins), 128'(expBeat(0)));
  endtask
  task automatic clr();
    vCnt = 0; sofCnt = 0; errCnt = 0; maxRun = 0;
  endtask
  task automatic counts(input string tag, input int v, input int s, input int m, input int e);
    chk({tag, "_valid"}, 128'(vCnt), 128'(v));
    chk({tag, "_sof"}, 128'(sofCnt), 128'(s));
    chk({tag, "_run"}, 128'(maxRun), 128'(m));
    chk({tag, "_err"}, 128'(errCnt), 128'(e));
  endtask
  initial begin
    idle(2);
    chk("reset_out", 128'({out_valid, out_sof, frame_err, outBins}), 128'(0));
    rst = 0;
    idle(2);
    clr();
    latFrame("single");
    idle(40);
    counts("single", 32, 1, 32, 0);
    clr();
    frame(0); frame(0); frame(0);
    idle(40);
    counts("three", 96, 3, 96, 0);
    clr();
    frame(2);
    idle(40);
    counts("gapped", 32, 1, 32, 0);
    clr();
    mode = 2;
    for (int c = 0; c < 10; c++) beat(c, c == 0);
    mode = 0;
    frame(0);
    idle(40);
    counts("resof", 32, 1, 32, 1);
    clr();
    beat(5, 0);
    idle(40);
    counts("nosof", 0, 0, 0, 1);
    frame(0);
    idle(40);
    counts("nosof_next", 32, 1, 32, 1);
    clr();
    latFrame("prerst");
    repeat (5) @(posedge clk);
    #1;
    chk("beat5_valid", 128'(out_valid), 128'(1));
    rst = 1;
    #1;
    chk("rst_async", 128'({out_valid, out_sof, outBins}), 128'(0));
    @(posedge clk); #1;
    rst = 0;
    clr();
    frame(0);
    idle(40);
    counts("postrst", 32, 1, 32, 0);
    clr();
    mode = 1;
    latFrame("extreme");
    chk("extreme_bin0", 128'(out_bin0), 128'({15'h4000, 15'h3FFF}));
    idle(40);
    counts("extreme", 32, 1, 32, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
